// File: rtl/race_controller_pkg.sv
// Shared definitions for the race game: game-state encoding broadcast to the
// physics engines and display, output widths, winner codes and the default
// race-timer ceiling.
package race_controller_pkg;

  // Value 2 is reserved and is never driven on the state bus.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } race_state_e;

  localparam int TIME_W        = 14;   // race_time / win_time width (centiseconds)
  localparam int DIGIT_W       = 4;    // countdown digit width
  localparam int TIME_MAX_DFLT = 9999; // default race-timer saturation value

  // Winner codes; a tie is both bits set, which lets the finish logic build the
  // code directly as {p2_edge, p1_edge}.
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

endpackage

// File: rtl/race_controller_tick_divider.sv
// tick_divider: free-running modulo-DIV prescaler that emits a one-cycle tick
// on every DIV-th enabled clock.
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears the count
//   clr  : synchronous clear, wins over en; no tick while clearing
//   en   : advance the count; when low the count is held frozen
//   tick : high for one cycle as the count wraps from DIV-1 to 0
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/race_controller.sv
// race_controller: game-flow controller for a two-player race. Walks through
// IDLE -> SETTING -> COUNTDOWN -> RACING <-> PAUSE -> FINISH, runs the
// countdown digit on a 1 s tick and the race timer on a 10 ms tick, and
// latches the winner and winning time from the physics engines' finish flags.
//   clk          : system clock (CLK_FREQ Hz)
//   rst          : asynchronous active-high reset
//   start_btn    : debounced start/confirm level
//   pause_btn    : debounced pause/resume level
//   abort_btn    : debounced return-to-idle level
//   p1_finish    : finish level from physics engine 1
//   p2_finish    : finish level from physics engine 2
//   state        : game state broadcast (race_state_e encoding)
//   count_digit  : countdown digit, 0 = GO
//   race_time    : elapsed race time in centiseconds, saturates at TIME_MAX
//   winner       : 0 none, 1 P1, 2 P2, 3 tie
//   win_time     : race_time captured in the winning cycle
module race_controller
  import race_controller_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int COUNT_SECS = 3,
  parameter int TIME_MAX   = TIME_MAX_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               abort_btn,
  input  logic               p1_finish,
  input  logic               p2_finish,
  output logic [2:0]         state,
  output logic [DIGIT_W-1:0] count_digit,
  output logic [TIME_W-1:0]  race_time,
  output logic [1:0]         winner,
  output logic [TIME_W-1:0]  win_time
);

  localparam int                 CS_DIV     = (CLK_FREQ / 100 > 0) ? CLK_FREQ / 100 : 1;
  localparam logic [TIME_W-1:0]  TIME_LIMIT = TIME_W'(TIME_MAX);
  localparam logic [DIGIT_W-1:0] DIGIT_INIT = DIGIT_W'(COUNT_SECS);

  race_state_e         state_q, state_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [TIME_W-1:0]   race_q, race_d;
  logic [1:0]          winner_q, winner_d;
  logic [TIME_W-1:0]   win_time_q, win_time_d;

  // Edge-detect history. armed_q stays low for the first clock after reset so
  // a level already high when reset releases loads the history silently
  // instead of looking like a fresh press.
  logic start_q, pause_q, abort_q, p1_q, p2_q;
  logic armed_q;

  logic start_p, pause_p, abort_p, p1_e, p2_e;
  logic sec_en, sec_clr, sec_tick;
  logic cs_en, cs_clr, cs_tick;
  logic go_idle;

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (v >= TIME_LIMIT) ? TIME_LIMIT : v + 1'b1;
  endfunction

  assign start_p = start_btn & ~start_q & armed_q;
  assign pause_p = pause_btn & ~pause_q & armed_q;
  assign abort_p = abort_btn & ~abort_q & armed_q;
  assign p1_e    = p1_finish & ~p1_q    & armed_q;
  assign p2_e    = p2_finish & ~p2_q    & armed_q;

  // The 1 s prescaler only runs in COUNTDOWN and sits at zero elsewhere, so
  // entering COUNTDOWN always starts a full second. The 10 ms prescaler keeps
  // its value through PAUSE so a resumed race does not lose a partial tick.
  assign sec_en  = (state_q == ST_COUNTDOWN);
  assign sec_clr = ~sec_en;
  assign cs_en   = (state_q == ST_RACING);
  assign cs_clr  = ~((state_q == ST_RACING) | (state_q == ST_PAUSE));

  tick_divider #(.DIV(CLK_FREQ)) u_sec_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (sec_clr),
    .en   (sec_en),
    .tick (sec_tick)
  );

  tick_divider #(.DIV(CS_DIV)) u_cs_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (cs_clr),
    .en   (cs_en),
    .tick (cs_tick)
  );

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    race_d     = race_q;
    winner_d   = winner_q;
    win_time_d = win_time_q;
    go_idle    = 1'b0;

    if (abort_p) begin
      go_idle = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p) state_d = ST_SETTING;
        end
        ST_SETTING: begin
          if (start_p) begin
            state_d = ST_COUNTDOWN;
            digit_d = DIGIT_INIT;
          end
        end
        ST_COUNTDOWN: begin
          if (sec_tick) begin
            if (digit_q <= 4'd1) begin
              state_d = ST_RACING;
              digit_d = '0;
              race_d  = '0;
            end else begin
              digit_d = digit_q - 4'd1;
            end
          end
        end
        ST_RACING: begin
          // Finish beats pause; the timer is frozen at the winning value.
          if (p1_e | p2_e) begin
            state_d    = ST_FINISH;
            winner_d   = {p2_e, p1_e};
            win_time_d = race_q;
          end else begin
            if (cs_tick) race_d = sat_inc(race_q);
            if (pause_p) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_p) state_d = ST_RACING;
        end
        ST_FINISH: begin
          if (start_p) go_idle = 1'b1;
        end
        default: begin
          go_idle = 1'b1;
        end
      endcase
    end

    if (go_idle) begin
      state_d    = ST_IDLE;
      digit_d    = '0;
      race_d     = '0;
      winner_d   = WIN_NONE;
      win_time_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      digit_q    <= '0;
      race_q     <= '0;
      winner_q   <= WIN_NONE;
      win_time_q <= '0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      abort_q    <= 1'b0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      race_q     <= race_d;
      winner_q   <= winner_d;
      win_time_q <= win_time_d;
      start_q    <= start_btn;
      pause_q    <= pause_btn;
      abort_q    <= abort_btn;
      p1_q       <= p1_finish;
      p2_q       <= p2_finish;
      armed_q    <= 1'b1;
    end
  end

  assign state       = state_q;
  assign count_digit = digit_q;
  assign race_time   = race_q;
  assign winner      = winner_q;
  assign win_time    = win_time_q;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller with a 1 kHz clock model (1 s = 1000 cycles,
// 10 ms = 10 cycles). The timer ceiling is lowered to 150 so saturation is
// reached in a short run.
module tb_race_controller;

  localparam int CLK  = 1000;
  localparam int CS   = CLK / 100;
  localparam int SECS = 3;
  localparam int TMAX = 150;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0, pause_btn = 1'b0, abort_btn = 1'b0;
  logic        p1_finish = 1'b0, p2_finish = 1'b0;
  logic [2:0]  state;
  logic [3:0]  count_digit;
  logic [13:0] race_time;
  logic [1:0]  winner;
  logic [13:0] win_time;

  int n_vec = 0;
  int n_err = 0;

  race_controller #(.CLK_FREQ(CLK), .COUNT_SECS(SECS), .TIME_MAX(TMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .abort_btn   (abort_btn),
    .p1_finish   (p1_finish),
    .p2_finish   (p2_finish),
    .state       (state),
    .count_digit (count_digit),
    .race_time   (race_time),
    .winner      (winner),
    .win_time    (win_time)
  );

  always #5 clk = ~clk;

  // Behavioural reference: the race clock is derived from the number of
  // cycles spent racing (act) and the countdown from cycles spent counting.
  int m_state = 0, m_digit = 0, m_race = 0, m_win = 0, m_wt = 0;
  int cd = 0, act = 0;
  bit h_s = 0, h_p = 0, h_a = 0, h_1 = 0, h_2 = 0, armed = 0;

  task automatic chk(input string name, input int act_v, input int exp_v);
    n_vec++;
    if (act_v != exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act_v, exp_v);
    end
  endtask

  task automatic m_idle();
    m_state = 0; m_digit = 0; m_race = 0; m_win = 0; m_wt = 0;
  endtask

  task automatic model_step();
    bit sp, pp, ap, f1, f2;
    if (rst) begin
      m_idle(); cd = 0; act = 0;
      h_s = 0; h_p = 0; h_a = 0; h_1 = 0; h_2 = 0; armed = 0;
      return;
    end
    sp = start_btn && !h_s && armed;
    pp = pause_btn && !h_p && armed;
    ap = abort_btn && !h_a && armed;
    f1 = p1_finish && !h_1 && armed;
    f2 = p2_finish && !h_2 && armed;
    h_s = start_btn; h_p = pause_btn; h_a = abort_btn;
    h_1 = p1_finish; h_2 = p2_finish; armed = 1;
    if (ap) begin
      m_idle();
      return;
    end
    case (m_state)
      0: if (sp) m_state = 1;
      1: if (sp) begin m_state = 3; cd = 0; m_digit = SECS; end
      3: begin
        cd++;
        m_digit = SECS - cd / CLK;
        if (m_digit == 0) begin m_state = 4; act = 0; m_race = 0; end
      end
      4: begin
        if (f1 || f2) begin
          m_state = 6;
          m_win   = (f1 ? 1 : 0) + (f2 ? 2 : 0);
          m_wt    = m_race;
        end else begin
          act++;
          m_race = (act / CS > TMAX) ? TMAX : act / CS;
          if (pp) m_state = 5;
        end
      end
      5: if (pp) m_state = 4;
      6: if (sp) m_idle();
      default: m_idle();
    endcase
  endtask

  // Per-cycle comparison against the model, 1 time unit after each edge.
  always begin
    @(posedge clk);
    model_step();
    #1;
    chk("state",       int'(state),       m_state);
    chk("count_digit", int'(count_digit), m_digit);
    chk("race_time",   int'(race_time),   m_race);
    chk("winner",      int'(winner),      m_win);
    chk("win_time",    int'(win_time),    m_wt);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two start presses: ends half a cycle after the COUNTDOWN entry edge.
  task automatic to_countdown();
    start_btn = 1; cyc(1); start_btn = 0; cyc(1);
    start_btn = 1; cyc(1); start_btn = 0;
  endtask

  task automatic press_start_to_idle();
    start_btn = 1; cyc(1); start_btn = 0; cyc(2);
  endtask

  initial begin
    // Reset with start held through deassertion: no pulse may result.
    start_btn = 1;
    cyc(3);
    chk("reset state", int'(state), 0);
    chk("reset race_time", int'(race_time), 0);
    rst = 0;
    cyc(3);
    chk("held start after reset", int'(state), 0);
    start_btn = 0; cyc(2);

    // Start, start, countdown 3-2-1-GO at 1000-cycle steps.
    start_btn = 1; cyc(1);
    chk("idle->setting", int'(state), 1);
    start_btn = 0; cyc(1);
    start_btn = 1; cyc(1);
    chk("setting->countdown", int'(state), 3);
    chk("countdown load", int'(count_digit), 3);
    start_btn = 0;
    cyc(999);
    chk("digit before 1st tick", int'(count_digit), 3);
    cyc(1);
    chk("digit after 1000", int'(count_digit), 2);
    chk("model digit after 1000", m_digit, 2);
    cyc(1000);
    chk("digit after 2000", int'(count_digit), 1);
    cyc(999);
    chk("still countdown at 2999", int'(state), 3);
    cyc(1);
    chk("racing at 3000", int'(state), 4);
    chk("GO digit", int'(count_digit), 0);

    // 250 racing cycles, pause 500, resume.
    cyc(250);
    chk("race_time after 250", int'(race_time), 25);
    chk("model race after 250", m_race, 25);
    pause_btn = 1; cyc(1);
    chk("pause entered", int'(state), 5);
    pause_btn = 0; cyc(499);
    chk("race_time frozen in pause", int'(race_time), 25);
    pause_btn = 1; cyc(1);
    chk("resumed", int'(state), 4);
    pause_btn = 0; cyc(49);
    chk("race_time after resume", int'(race_time), 30);

    // Simultaneous finish at race_time 42 -> tie.
    cyc(125);
    chk("race_time before finish", int'(race_time), 42);
    p1_finish = 1; p2_finish = 1; cyc(1);
    chk("finish state", int'(state), 6);
    chk("tie winner", int'(winner), 3);
    chk("tie win_time", int'(win_time), 42);
    p2_finish = 0; cyc(3); p2_finish = 1; cyc(3);
    chk("late p2 winner", int'(winner), 3);
    chk("late p2 win_time", int'(win_time), 42);
    chk("race_time held in finish", int'(race_time), 42);
    p1_finish = 0; p2_finish = 0;
    start_btn = 1; cyc(1);
    chk("finish->idle", int'(state), 0);
    chk("idle clears winner", int'(winner), 0);
    chk("idle clears win_time", int'(win_time), 0);
    start_btn = 0; cyc(2);

    // P2 finish coinciding with a pause press.
    to_countdown();
    cyc(3000 + $urandom_range(20, 300));
    p2_finish = 1; pause_btn = 1; cyc(1);
    chk("finish beats pause state", int'(state), 6);
    chk("p2 winner", int'(winner), 2);
    cyc(2);
    chk("no pause after finish", int'(state), 6);
    p2_finish = 0; pause_btn = 0;
    press_start_to_idle();

    // Abort in COUNTDOWN on digit 2.
    to_countdown();
    cyc(1000);
    chk("digit 2 before abort", int'(count_digit), 2);
    abort_btn = 1; cyc(1);
    chk("abort -> idle", int'(state), 0);
    chk("abort clears digit", int'(count_digit), 0);
    abort_btn = 0; cyc(2);

    // Asynchronous reset mid-race.
    to_countdown();
    cyc(3000 + 200);
    chk("racing before rst", int'(race_time), 20);
    rst = 1; #1;
    chk("async rst state", int'(state), 0);
    chk("async rst digit", int'(count_digit), 0);
    chk("async rst race_time", int'(race_time), 0);
    chk("async rst winner", int'(winner), 0);
    chk("async rst win_time", int'(win_time), 0);
    cyc(2); rst = 0; cyc(2);

    // Saturation of the race timer.
    to_countdown();
    cyc(3000 + TMAX * CS + 300);
    chk("race_time saturated", int'(race_time), TMAX);
    chk("still racing at saturation", int'(state), 4);
    abort_btn = 1; cyc(1); abort_btn = 0; cyc(2);

    // Randomised play checked cycle by cycle against the model.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199)   == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 99)    == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 7999)  == 0) abort_btn = ~abort_btn;
      if ($urandom_range(0, 299)   == 0) p1_finish = ~p1_finish;
      if ($urandom_range(0, 299)   == 0) p2_finish = ~p2_finish;
      rst = ($urandom_range(0, 14999) == 0);
    end
    rst = 0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
